// File: rtl/module_mult_booth_ctrl.sv
// module_mult_booth_ctrl: control FSM for the radix-2 Booth multiplier datapath.
// Sequences load, N x (optional add/sub + arithmetic shift), then holds done until ack.
// Optional build macro: MULT_BOOTH_PERF_CNT_EN adds a 'cycles' output holding the
// busy-cycle count of the most recent completed multiplication.
module module_mult_booth_ctrl #(
   parameter int unsigned N = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       ready,
   input  logic       ack,
   input  logic [2:0] Q_LSB,
   output logic       load_A,
   output logic       load_B,
   output logic       load_add,
   output logic       add_sub,
   output logic       shift_HQ_LQ_Q_1,
   output logic       busy,
`ifdef MULT_BOOTH_PERF_CNT_EN
   output logic       done,
   output logic [$clog2(3*N+2)-1:0] cycles
`else
   output logic       done
`endif
);

   localparam int unsigned CNT_W = $clog2(N+1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               add_sub_q, add_sub_d;
   logic               ready_q, ready_d;
   logic               load_ab_q, load_ab_d;
   logic               load_add_q, load_add_d;
   logic               shift_q, shift_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Q_LSB[2] is datapath status this block has no use for
   logic               unused_q_lsb2;
   assign unused_q_lsb2 = Q_LSB[2];

   // Next-state, counter and add/sub latch; strobes are decoded from the next state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      add_sub_d  = add_sub_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            cnt_d   = CNT_W'(N);
            state_d = CHECK;
         end
         CHECK: begin
            case (Q_LSB[1:0])
               2'b01: begin
                  state_d   = ADD;
                  add_sub_d = 1'b0;
               end
               2'b10: begin
                  state_d   = ADD;
                  add_sub_d = 1'b1;
               end
               default: state_d = SHIFT;
            endcase
         end
         ADD: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_q == CNT_W'(1)) ? DONE : CHECK;
         end
         DONE: begin
            if (ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      ready_d    = (state_d == IDLE);
      load_ab_d  = (state_d == LOAD);
      load_add_d = (state_d == ADD);
      shift_d    = (state_d == SHIFT);
      done_d     = (state_d == DONE);
      busy_d     = (state_d != IDLE) && (state_d != DONE);
   end

   // State, counter and registered Moore outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         add_sub_q  <= 1'b0;
         ready_q    <= 1'b1;
         load_ab_q  <= 1'b0;
         load_add_q <= 1'b0;
         shift_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         add_sub_q  <= add_sub_d;
         ready_q    <= ready_d;
         load_ab_q  <= load_ab_d;
         load_add_q <= load_add_d;
         shift_q    <= shift_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ready           = ready_q;
   assign load_A          = load_ab_q;
   assign load_B          = load_ab_q;
   assign load_add        = load_add_q;
   assign add_sub         = add_sub_q;
   assign shift_HQ_LQ_Q_1 = shift_q;
   assign busy            = busy_q;
   assign done            = done_q;

`ifdef MULT_BOOTH_PERF_CNT_EN
   localparam int unsigned CYC_W = $clog2(3*N+2);

   logic [CYC_W-1:0] perf_q, perf_d;
   logic [CYC_W-1:0] cycles_q, cycles_d;

   // Busy-cycle counter; the final SHIFT cycle is included when publishing the total
   always_comb begin
      perf_d   = perf_q;
      cycles_d = cycles_q;
      if (state_d == LOAD) begin
         perf_d = '0;
      end else if (busy_q) begin
         perf_d = perf_q + CYC_W'(1);
      end
      if ((state_q == SHIFT) && (state_d == DONE)) begin
         cycles_d = perf_q + CYC_W'(1);
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_q   <= '0;
         cycles_q <= '0;
      end else begin
         perf_q   <= perf_d;
         cycles_q <= cycles_d;
      end
   end

   assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_module_mult_booth_ctrl.sv
// Scoreboard bench for module_mult_booth_ctrl with a behavioural Booth datapath
// that feeds Q_LSB back, so the FSM runs real operand patterns.
`timescale 1ns/1ps
module tb_module_mult_booth_ctrl;
   localparam int unsigned N     = 8;
   localparam int unsigned CYC_W = $clog2(3*N+2);

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic start = 1'b0;
   logic ack   = 1'b0;
   logic [2:0] q_lsb;
   logic ready, load_A, load_B, load_add, add_sub, shift_s, busy, done;
`ifdef MULT_BOOTH_PERF_CNT_EN
   logic [CYC_W-1:0] cycles;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0]  lat;
      logic [7:0]  k;
      logic [7:0]  seq;
      logic [15:0] y;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   module_mult_booth_ctrl #(.N(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .ready           (ready),
      .ack             (ack),
      .Q_LSB           (q_lsb),
      .load_A          (load_A),
      .load_B          (load_B),
      .load_add        (load_add),
      .add_sub         (add_sub),
      .shift_HQ_LQ_Q_1 (shift_s),
      .busy            (busy),
`ifdef MULT_BOOTH_PERF_CNT_EN
      .done            (done),
      .cycles          (cycles)
`else
      .done            (done)
`endif
   );

   // Reference Booth datapath driven by the DUT strobes
   logic [7:0] op_a = 8'h00;
   logic [7:0] op_b = 8'h00;
   logic [7:0] m_r, acc_r, q_r;
   logic       q1_r;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_r <= 8'h00; acc_r <= 8'h00; q_r <= 8'h00; q1_r <= 1'b0;
      end else begin
         if (load_A) begin m_r <= op_a; acc_r <= 8'h00; end
         if (load_B) begin q_r <= op_b; q1_r <= 1'b0; end
         if (load_add) acc_r <= add_sub ? (acc_r - m_r) : (acc_r + m_r);
         if (shift_s) {acc_r, q_r, q1_r} <= {acc_r[7], acc_r, q_r};
      end
   end
   assign q_lsb = {1'b0, q_r[0], q1_r};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: tracks each accepted request and scores it when done rises
   initial begin
      int         cyc;
      int         adds;
      int         shifts;
      logic [7:0] seq;
      bit         active;
      bit         done_prev;
      exp_t       e;
      cyc = 0; adds = 0; shifts = 0; seq = 8'h00; active = 0; done_prev = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            active    = 0;
            done_prev = 0;
         end else begin
            if (active) begin
               cyc++;
               if (load_add) begin adds++; seq = {seq[6:0], add_sub}; end
               if (shift_s) shifts++;
               if (done && !done_prev) begin
                  active = 0;
                  if (sb_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL sb_underflow: done with no expected entry, cyc %0d", cyc);
                  end else begin
                     e = sb_q.pop_front();
                     chk("latency", 32'(cyc - 1), 32'(e.lat));
                     chk("add_count", 32'(adds), 32'(e.k));
                     chk("shift_count", 32'(shifts), 32'(N));
                     chk("add_sub_seq", 32'(seq), 32'(e.seq));
                     chk("product", 32'({acc_r, q_r}), 32'(e.y));
`ifdef MULT_BOOTH_PERF_CNT_EN
                     chk("perf_cycles", 32'(cycles), 32'(e.lat));
`endif
                  end
               end
            end
            if (ready && start) begin
               active = 1; cyc = 0; adds = 0; shifts = 0; seq = 8'h00;
            end
            done_prev = done;
         end
      end
   end

   task automatic push_exp(input int lat, input int k, input logic [7:0] seq, input logic [15:0] y);
      exp_t e;
      e.lat = 8'(lat);
      e.k   = 8'(k);
      e.seq = seq;
      e.y   = y;
      sb_q.push_back(e);
   endtask

   // Wait for done; optionally pokes start and ack once during the first SHIFT
   task automatic wait_done(input bit poke);
      bit ok;
      bit poked;
      ok = 0; poked = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (poke && shift_s && !poked) begin
            start = 1'b1; ack = 1'b1; poked = 1;
         end else begin
            start = 1'b0; ack = 1'b0;
         end
         if (done) begin ok = 1; break; end
      end
      chk("done_seen", 32'(ok), 32'd1);
   endtask

   task automatic ack_pulse();
      @(posedge clk); #1 ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
      @(negedge clk);
      chk("idle_after_ack", 32'({ready, done, busy}), 32'b100);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int lat, input int k,
                         input logic [7:0] seq, input logic [15:0] y, input int hold, input bit poke);
      op_a = a; op_b = b;
      push_exp(lat, k, seq, y);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(poke);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_quiet", 32'({load_A, load_B, load_add, shift_s, busy, done}), 32'b000001);
      end
      ack_pulse();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #12;
      chk("reset_outputs", 32'({ready, busy, done, load_A, load_B, load_add, shift_s, add_sub}),
          32'b1000_0000);
      @(negedge clk); rst = 1'b1;

      // Mixed sub/add pattern, B=0E: sub at iteration 1, add at iteration 4
      run_op(8'h0B, 8'h0E, 19, 2, 8'h02, 16'h009A, 0, 0);
      // No add/sub at all
      run_op(8'h5A, 8'h00, 17, 0, 8'h00, 16'h0000, 0, 0);
      // Single subtract at iteration 0
      run_op(8'h03, 8'hFF, 18, 1, 8'h01, 16'hFFFD, 0, 0);
      // Add/sub every iteration, long done hold before ack
      run_op(8'h03, 8'h55, 25, 8, 8'hAA, 16'h00FF, 10, 0);
      // start and ack poked during SHIFT must be ignored
      run_op(8'h0B, 8'h0E, 19, 2, 8'h02, 16'h009A, 0, 1);

      // start held high: ack with start returns to IDLE, next edge accepts
      op_a = 8'h5A; op_b = 8'h00;
      push_exp(17, 0, 8'h00, 16'h0000);
      push_exp(17, 0, 8'h00, 16'h0000);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("held_first_done", 32'(done), 32'd1);
      @(posedge clk); #1 ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
      @(negedge clk);
      chk("ack_with_start_idle", 32'({ready, done, busy}), 32'b100);
      @(negedge clk);
      chk("accept_following_edge", 32'({ready, busy, load_A, load_B}), 32'b0111);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("held_second_done", 32'(done), 32'd1);
      start = 1'b0;
      ack_pulse();

      // Asynchronous reset in the 5th cycle of an operation
      op_a = 8'h03; op_b = 8'h55;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_outputs", 32'({ready, busy, done, load_A, load_B, load_add, shift_s, add_sub}),
          32'b1000_0000);
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      run_op(8'h5A, 8'h00, 17, 0, 8'h00, 16'h0000, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
